// File: rtl/router_reg.sv
// router_reg
// Datapath register stage of the 1x3 router. Driven by the router FSM's
// one-hot state decodes, it latches the header byte, steers header, payload
// and parity bytes onto dout for the FIFO write path, parks a byte that
// arrives while the target FIFO is full, and checks packet parity.
//
// Ports:
//   clock             sole clock, rising edge
//   reset             asynchronous, active-high; clears all state
//   pkt_valid         source byte valid; low on the parity byte
//   data_in[7:0]      source byte; header bits [1:0] are the port address
//   fifo_full         selected FIFO is full
//   detect_add        FSM in DECODE_ADDRESS
//   lfd_state         FSM in LOAD_FIRST_DATA
//   ld_state          FSM in LOAD_DATA
//   laf_state         FSM in LOAD_AFTER_FULL
//   full_state        FSM in FIFO_FULL_STATE
//   rst_int_reg       FSM in CHECK_PARITY_ERROR
//   dout[7:0]         registered byte for the FIFO write port
//   parity_done       registered; packet parity byte has been captured
//   low_packet_valid  registered; pkt_valid fell during LOAD_DATA
//   err               registered; parity mismatch for the current packet

module router_reg (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       detect_add,
    input  logic       lfd_state,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       rst_int_reg,
    output logic [7:0] dout,
    output logic       parity_done,
    output logic       low_packet_valid,
    output logic       err
);

    logic [7:0] header_byte;
    logic [7:0] full_byte;
    logic [7:0] int_parity;
    logic [7:0] pkt_parity;

    // Address 3 is not a valid port, so such a header never overwrites the
    // previously latched one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            header_byte <= 8'h00;
        else if (detect_add && pkt_valid && data_in[1:0] != 2'b11)
            header_byte <= data_in;
    end

    // Byte presented to the FIFO. While LOAD_DATA sees a full FIFO, dout
    // holds and the incoming byte is parked in full_byte instead; it is
    // replayed on the LOAD_AFTER_FULL edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            dout <= 8'h00;
        else if (lfd_state)
            dout <= header_byte;
        else if (ld_state && !fifo_full)
            dout <= data_in;
        else if (laf_state)
            dout <= full_byte;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            full_byte <= 8'h00;
        else if (ld_state && fifo_full)
            full_byte <= data_in;
    end

    // Running XOR over header and payload. The parked byte is accumulated
    // on the edge it is captured (full_state is still low then), so it must
    // not be folded in again in LOAD_AFTER_FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            int_parity <= 8'h00;
        else if (detect_add)
            int_parity <= 8'h00;
        else if (lfd_state)
            int_parity <= int_parity ^ header_byte;
        else if (ld_state && pkt_valid && !full_state)
            int_parity <= int_parity ^ data_in;
    end

    // The parity byte is captured either directly from data_in, or from
    // full_byte when it was the byte parked during a full stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_parity  <= 8'h00;
            parity_done <= 1'b0;
        end else if (ld_state && !fifo_full && !pkt_valid) begin
            pkt_parity  <= data_in;
            parity_done <= 1'b1;
        end else if (laf_state && low_packet_valid && !parity_done) begin
            pkt_parity  <= full_byte;
            parity_done <= 1'b1;
        end else if (detect_add) begin
            pkt_parity  <= 8'h00;
            parity_done <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            low_packet_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_packet_valid <= 1'b1;
        else if (rst_int_reg)
            low_packet_valid <= 1'b0;
    end

    // err is sticky for the rest of the packet; only the next
    // DECODE_ADDRESS cycle clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (detect_add)
            err <= 1'b0;
        else if (parity_done && (int_parity != pkt_parity))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg
// Self-checking bench for router_reg. The bench plays the role of the router
// FSM, sequencing whole packets (decode, first data, payload, optional full
// stall, parity check) and comparing the DUT outputs with a packet-level
// reference model: the latched header, the last byte written to the FIFO,
// and the XOR of header and payload against the packet's parity byte.

module tb_router_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_packet_valid;
    logic       err;

    int total_checks = 0;
    int fail_count   = 0;

    // Reference model state
    logic [7:0] model_header = 8'h00;
    logic [7:0] model_dout   = 8'h00;
    logic [7:0] payload_q[$];

    router_reg dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total_checks++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    // Sends header + payload_q + parity. full_idx selects which byte (index
    // into payload, or payload size for the parity byte) meets a full FIFO;
    // -1 means no stall.
    task automatic applyStimulus(input logic [7:0] header, input logic [7:0] parity,
                                 input int full_idx, input int full_cycles);
        logic [7:0] exp_parity;
        logic [7:0] b;
        logic       last;
        logic       exp_err;
        int         n;
        n = payload_q.size();

        @(negedge clock);
        idleInputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = header;
        stepClock();
        if (header[1:0] != 2'b11)
            model_header = header;
        checkOutput("err_clear_on_decode", {7'b0, err}, 8'h00);
        checkOutput("pdone_clear_on_decode", {7'b0, parity_done}, 8'h00);
        checkOutput("dout_hold_decode", dout, model_dout);

        @(negedge clock);
        idleInputs();
        lfd_state = 1'b1;
        pkt_valid = 1'b1;
        data_in   = payload_q[0];
        stepClock();
        model_dout = model_header;
        checkOutput("dout_header", dout, model_dout);
        exp_parity = model_header;

        for (int i = 0; i <= n; i++) begin
            last = (i == n);
            b    = last ? parity : payload_q[i];
            @(negedge clock);
            idleInputs();
            ld_state  = 1'b1;
            pkt_valid = !last;
            data_in   = b;
            fifo_full = (i == full_idx);
            stepClock();
            if (!last)
                exp_parity = exp_parity ^ b;
            if (i != full_idx) begin
                model_dout = b;
                checkOutput("dout_load", dout, model_dout);
                if (last)
                    checkOutput("pdone_direct", {7'b0, parity_done}, 8'h01);
            end else begin
                checkOutput("dout_hold_full", dout, model_dout);
                for (int k = 0; k < full_cycles; k++) begin
                    @(negedge clock);
                    idleInputs();
                    full_state = 1'b1;
                    fifo_full  = 1'b1;
                    pkt_valid  = !last;
                    data_in    = b;
                    stepClock();
                    checkOutput("dout_hold_fullstate", dout, model_dout);
                    checkOutput("lpv_fullstate", {7'b0, low_packet_valid}, {7'b0, last});
                    checkOutput("pdone_fullstate", {7'b0, parity_done}, 8'h00);
                end
                @(negedge clock);
                idleInputs();
                laf_state = 1'b1;
                pkt_valid = !last;
                data_in   = b;
                stepClock();
                model_dout = b;
                checkOutput("dout_after_full", dout, model_dout);
                checkOutput("pdone_after_full", {7'b0, parity_done}, {7'b0, last});
            end
            checkOutput("err_low_in_packet", {7'b0, err}, 8'h00);
            if (last)
                checkOutput("lpv_set", {7'b0, low_packet_valid}, 8'h01);
        end

        exp_err = (exp_parity != parity);
        @(negedge clock);
        idleInputs();
        rst_int_reg = 1'b1;
        stepClock();
        checkOutput("err_check", {7'b0, err}, {7'b0, exp_err});
        checkOutput("lpv_cleared", {7'b0, low_packet_valid}, 8'h00);
        checkOutput("pdone_held", {7'b0, parity_done}, 8'h01);

        @(negedge clock);
        idleInputs();
        stepClock();
        checkOutput("err_sticky", {7'b0, err}, {7'b0, exp_err});
        checkOutput("dout_idle_hold", dout, model_dout);
    endtask

    // Reset asserted in LOAD_DATA with the running parity at 0x5C.
    task automatic resetMidPacket();
        @(negedge clock);
        idleInputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h5C;
        stepClock();
        @(negedge clock);
        idleInputs();
        lfd_state = 1'b1;
        pkt_valid = 1'b1;
        stepClock();
        @(negedge clock);
        idleInputs();
        ld_state  = 1'b1;
        pkt_valid = 1'b1;
        data_in   = 8'h00;
        stepClock();
        checkOutput("int_parity_before_reset", dut.int_parity, 8'h5C);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_dout", dout, 8'h00);
        checkOutput("async_rst_err", {7'b0, err}, 8'h00);
        checkOutput("async_rst_pdone", {7'b0, parity_done}, 8'h00);
        checkOutput("async_rst_lpv", {7'b0, low_packet_valid}, 8'h00);
        checkOutput("async_rst_int_parity", dut.int_parity, 8'h00);
        idleInputs();
        @(negedge clock);
        reset = 1'b0;
        model_header = 8'h00;
        model_dout   = 8'h00;
    endtask

    initial begin
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] eff_hdr;
        int         len;
        int         fidx;

        idleInputs();
        reset = 1'b1;
        #2;
        checkOutput("reset_dout", dout, 8'h00);
        checkOutput("reset_err", {7'b0, err}, 8'h00);
        checkOutput("reset_pdone", {7'b0, parity_done}, 8'h00);
        checkOutput("reset_lpv", {7'b0, low_packet_valid}, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Address 3 right after reset: header stays 0
        payload_q = '{8'h10};
        applyStimulus(8'h03, 8'h10, -1, 0);

        // Good parity
        payload_q = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h01, 8'h01, -1, 0);

        // Bad parity
        payload_q = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h01, 8'hFF, -1, 0);

        // Full on second payload byte for 3 cycles
        payload_q = '{8'hA5, 8'h5A};
        applyStimulus(8'h02, 8'hFD, 1, 3);

        // Full on the parity byte
        payload_q = '{8'hA5, 8'h5A};
        applyStimulus(8'h02, 8'hFD, 2, 2);

        resetMidPacket();

        // Clean packet after mid-packet reset
        payload_q = '{8'h44, 8'h55};
        applyStimulus(8'h01, 8'h01 ^ 8'h44 ^ 8'h55, -1, 0);

        for (int p = 0; p < 40; p++) begin
            hdr = 8'($urandom);
            len = $urandom_range(1, 8);
            payload_q = {};
            eff_hdr = (hdr[1:0] != 2'b11) ? hdr : model_header;
            par = eff_hdr;
            for (int j = 0; j < len; j++) begin
                payload_q.push_back(8'($urandom));
                par = par ^ payload_q[j];
            end
            if ($urandom_range(0, 1) == 0)
                par = 8'($urandom);
            fidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
            applyStimulus(hdr, par, fidx, $urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
        $finish;
    end

endmodule
